mem_ram_hs: RTL and testbench
=============================

Name: mem_ram_hs

Overview:
- Parametrised single-port data RAM for the core's load/store path, next generation of the simulated RAM.
- Byte-maskable writes, configurable wait-state latency, valid/ready request and response channels, and address range/alignment error reporting.
- Post-reset hardware clear engine replaces the per-word reset loop.
- Sits between the load/store unit (or bus interconnect) and storage; one outstanding transaction.

Parameters:
- DATA_WIDTH, 32, word width in bits; multiple of 8.
- ADDR_WIDTH, 32, byte address width.
- DEPTH, 256, number of words; power of 2, ≥ 2.
- LATENCY, 1, wait cycles between acceptance and response; 0..15.
- BASE_ADDR, 0, byte address of word 0; aligned to DATA_WIDTH/8.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents undefined at power-up.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  block can accept a request.
- req_addr_i  input  ADDR_WIDTH  byte address.
- req_wdata_i  input  DATA_WIDTH  write data.
- req_wmask_i  input  DATA_WIDTH/8  byte write enables; all-zero = read.
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  consumer takes response.
- rsp_rdata_o  output  DATA_WIDTH  read data.
- rsp_err_o  output  1  request was misaligned or out of range.
- busy_o  output  1  clear engine running or transaction in flight.

Behaviour:
- Reset (async, reset_n=0):
  - State CLEAR if CLEAR_ON_RESET, else IDLE; clear pointer=0; wait counter=0.
  - req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - busy_o=1 if CLEAR_ON_RESET, else 0.
  - Reset mid-transaction aborts it; no response is produced and a pending write that has not reached its commit edge is not performed.
- States: CLEAR, IDLE, WAIT, RESP.
- CLEAR:
  - Writes 0 to word[ptr] each cycle; ptr increments.
  - After writing word DEPTH-1, goes to IDLE; exactly DEPTH cycles.
  - req_ready_o=0, busy_o=1.
- IDLE:
  - req_ready_o=1, busy_o=0.
  - Acceptance edge E0 = rising edge with req_valid_i & req_ready_o; addr, wdata and wmask are latched at E0.
  - LATENCY=0: next state RESP. Otherwise: next state WAIT, counter=LATENCY.
- WAIT:
  - Counter decrements each edge; on the edge where counter==1, go to RESP.
  - req_ready_o=0, busy_o=1.
- Commit (edge entering RESP, i.e. E0+LATENCY):
  - Offset = addr - BASE_ADDR.
  - err = (offset low log2(DATA_WIDTH/8) bits ≠ 0) or (offset ≥ DEPTH*DATA_WIDTH/8) or (addr < BASE_ADDR).
  - err=1: no memory access; rsp_rdata_o=0; rsp_err_o=1.
  - Read (mask==0): rsp_rdata_o = word[offset>>log2(DATA_WIDTH/8)].
  - Write: byte lane k is written iff mask[k]; unmasked lanes keep old value; rsp_rdata_o=0.
- RESP:
  - rsp_valid_o=1; rsp_rdata_o and rsp_err_o held stable until handshake.
  - Edge with rsp_ready_i=1 → IDLE; rsp_valid_o=0 and rsp_err_o=0 after that edge; rsp_rdata_o retains its last value.
  - req_ready_o=0 in RESP, so there is no same-cycle back-to-back.
  - Minimum period is LATENCY+2 cycles per transaction.
- rsp_valid_o rises LATENCY+1 cycles after req_valid_i is first sampled high in IDLE (counted from the cycle of E0).
- Request inputs are ignored outside IDLE; changing them after E0 has no effect.
- rsp_ready_i is ignored outside RESP.
- Memory is a clocked array with no reset port; only the CLEAR engine and committed writes modify it.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=256: release reset → busy_o=1 for exactly 256 cycles, then req_ready_o=1; reading 0x3FC and 0x000 returns 0x00000000, err=0.
- LATENCY=1: write 0xDEADBEEF to 0x20 with mask 4'b1111, then read 0x20 → rsp_valid_o 2 cycles after acceptance; rdata=0xDEADBEEF.
- Byte mask: word 0x20=0xDEADBEEF, write 0x11223344 with mask 4'b0101 → read returns 0xDE22BE44.
- Errors: read 0x22 → err=1, rdata=0; write to 0x400 (DEPTH=256) → err=1, and word 0x000 is unchanged.
- Backpressure: hold rsp_ready_i=0 for 5 cycles → rsp_valid_o, rdata and err stay stable and req_ready_o=0; assert rsp_ready_i → IDLE next cycle.
- Parameter/reset sweep:
  - DATA_WIDTH=64, LATENCY=0, BASE_ADDR=0x1000: write 0x0123456789ABCDEF to 0x1008 with mask 8'hF0, then read → 0x01234567_00000000, response one cycle after acceptance.
  - Assert reset_n during WAIT → no response, and the write is not committed.

Source files
------------

// File: rtl/mem_ram_hs.sv
// Single-port data RAM with valid/ready request and response channels, byte-masked writes,
// programmable wait states, range/alignment error reporting and a post-reset clear engine.
module mem_ram_hs #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DEPTH          = 256,
  parameter int                    LATENCY        = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter bit                    CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_wmask_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    busy_o
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int LB        = $clog2(NUM_LANES);
  localparam int IW        = $clog2(DEPTH);
  localparam logic [63:0] MEM_BYTES = 64'(DEPTH * NUM_LANES);

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [NUM_LANES-1:0]  wmask;
  } req_t;

  logic [1:0]            r_state;
  logic [IW-1:0]         r_ptr;
  logic [3:0]            r_cnt;
  req_t                  r_req;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  req_t                  w_req;
  logic                  w_acc;
  logic                  w_commit;
  logic                  w_err;
  logic                  w_is_rd;
  logic [ADDR_WIDTH-1:0] w_off;
  logic [IW-1:0]         w_idx;
  logic [DATA_WIDTH-1:0] w_old;
  logic [DATA_WIDTH-1:0] w_new;

  assign req_ready_o = (r_state == S_IDLE) && reset_n;
  assign rsp_valid_o = (r_state == S_RESP);
  assign busy_o      = (r_state != S_IDLE);
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;

  // With zero wait states the commit edge is the acceptance edge, so use the live request.
  assign w_req    = (r_state == S_IDLE) ? {req_addr_i, req_wdata_i, req_wmask_i} : r_req;
  assign w_acc    = req_valid_i && req_ready_o;
  assign w_commit = reset_n && ((w_acc && (LATENCY == 0)) ||
                                ((r_state == S_WAIT) && (r_cnt == 4'd1)));

  assign w_off   = w_req.addr - BASE_ADDR;
  assign w_err   = (w_req.addr < BASE_ADDR) ||
                   ((w_off & ADDR_WIDTH'(NUM_LANES - 1)) != '0) ||
                   (64'(w_off) >= MEM_BYTES);
  assign w_idx   = IW'(w_off >> LB);
  assign w_is_rd = (w_req.wmask == '0);
  assign w_old   = r_mem[w_idx];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign w_new[g*8 +: 8] = w_req.wmask[g] ? w_req.wdata[g*8 +: 8] : w_old[g*8 +: 8];
  end

  // Storage has no reset; gating on reset_n keeps an aborted transaction from landing.
  always_ff @(posedge clk) begin
    if (reset_n && (r_state == S_CLEAR))
      r_mem[r_ptr] <= '0;
    else if (w_commit && !w_err && !w_is_rd)
      r_mem[w_idx] <= w_new;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_req   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == IW'(DEPTH - 1)) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (w_acc) begin
            r_req <= w_req;
            if (LATENCY == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(LATENCY);
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == 4'd1) r_state <= S_RESP;
        end
        default: begin
          if (rsp_ready_i) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
          end
        end
      endcase
      if (w_commit) begin
        r_rdata <= (w_err || !w_is_rd) ? '0 : w_old;
        r_err   <= w_err;
      end
    end
  end
endmodule

// File: tb/tb_mem_ram_hs.sv
// Directed scoreboard bench for mem_ram_hs: three instances cover the default build,
// a 64-bit zero-latency offset build, and a no-clear long-latency build for reset abort.
`timescale 1ns/1ps
module tb_mem_ram_hs;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1, rst2;
  logic [1:0]  sel;
  logic        t_valid, t_rready;
  logic [31:0] t_addr;
  logic [63:0] t_wdata;
  logic [7:0]  t_mask;

  logic        rdy0, vld0, e0, b0;
  logic [31:0] d0;
  logic        rdy1, vld1, e1, b1;
  logic [63:0] d1;
  logic        rdy2, vld2, e2, b2;
  logic [31:0] d2;

  logic        s_ready, s_vld, s_err, s_busy;
  logic [63:0] s_rdata;

  typedef struct {
    logic [63:0] d;
    logic        e;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;

  mem_ram_hs u0 (
    .clk(clk), .reset_n(rst0),
    .req_valid_i(t_valid && sel == 2'd0), .req_ready_o(rdy0),
    .req_addr_i(t_addr), .req_wdata_i(t_wdata[31:0]), .req_wmask_i(t_mask[3:0]),
    .rsp_valid_o(vld0), .rsp_ready_i(t_rready && sel == 2'd0),
    .rsp_rdata_o(d0), .rsp_err_o(e0), .busy_o(b0)
  );

  mem_ram_hs #(.DATA_WIDTH(64), .LATENCY(0), .BASE_ADDR(32'h1000), .DEPTH(16)) u1 (
    .clk(clk), .reset_n(rst1),
    .req_valid_i(t_valid && sel == 2'd1), .req_ready_o(rdy1),
    .req_addr_i(t_addr), .req_wdata_i(t_wdata), .req_wmask_i(t_mask),
    .rsp_valid_o(vld1), .rsp_ready_i(t_rready && sel == 2'd1),
    .rsp_rdata_o(d1), .rsp_err_o(e1), .busy_o(b1)
  );

  mem_ram_hs #(.LATENCY(3), .DEPTH(16), .CLEAR_ON_RESET(1'b0)) u2 (
    .clk(clk), .reset_n(rst2),
    .req_valid_i(t_valid && sel == 2'd2), .req_ready_o(rdy2),
    .req_addr_i(t_addr), .req_wdata_i(t_wdata[31:0]), .req_wmask_i(t_mask[3:0]),
    .rsp_valid_o(vld2), .rsp_ready_i(t_rready && sel == 2'd2),
    .rsp_rdata_o(d2), .rsp_err_o(e2), .busy_o(b2)
  );

  always_comb begin
    s_ready = rdy0; s_vld = vld0; s_err = e0; s_busy = b0; s_rdata = {32'd0, d0};
    if (sel == 2'd1) begin
      s_ready = rdy1; s_vld = vld1; s_err = e1; s_busy = b1; s_rdata = d1;
    end else if (sel == 2'd2) begin
      s_ready = rdy2; s_vld = vld2; s_err = e2; s_busy = b2; s_rdata = {32'd0, d2};
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction on the selected instance; hold = cycles of response backpressure.
  task automatic txn(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m,
                     input logic [63:0] ed, input logic ee, input int hold);
    int   lat, n;
    exp_t x;
    lat = (sel == 2'd0) ? 1 : (sel == 2'd1) ? 0 : 3;
    sb.push_back('{ed, ee});
    @(negedge clk);
    t_addr = a; t_wdata = d; t_mask = m; t_valid = 1'b1;
    chk("req_ready_idle", s_ready, 1);
    @(posedge clk); #1;
    t_valid = 1'b0; t_addr = ~a; t_wdata = ~d; t_mask = ~m;
    n = 0;
    while (!s_vld && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rsp_latency", n, lat);
    x = sb.pop_front();
    chk("rsp_rdata", s_rdata, x.d);
    chk("rsp_err", s_err, x.e);
    chk("req_ready_resp", s_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", s_vld, 1);
      chk("hold_rdata", s_rdata, x.d);
      chk("hold_err", s_err, x.e);
      chk("hold_ready", s_ready, 0);
    end
    @(negedge clk); t_rready = 1'b1;
    @(posedge clk); #1; t_rready = 1'b0;
    chk("post_valid", s_vld, 0);
    chk("post_err", s_err, 0);
    chk("post_ready", s_ready, 1);
    chk("post_rdata_kept", s_rdata, x.d);
  endtask

  initial begin
    int n;
    t_valid = 1'b0; t_rready = 1'b0; t_addr = '0; t_wdata = '0; t_mask = '0;
    sel = 2'd0; rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    #12;
    chk("rst_ready0", rdy0, 0);
    chk("rst_valid0", vld0, 0);
    chk("rst_rdata0", d0, 0);
    chk("rst_err0", e0, 0);
    chk("rst_busy0", b0, 1);
    chk("rst_busy2", b2, 0);
    chk("rst_ready2", rdy2, 0);
    @(negedge clk);
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (b0 && n < 300);
    chk("clear_cycles", n, 256);
    chk("ready_after_clear", rdy0, 1);

    // default build: 32-bit, one wait state
    txn(32'h3FC, 64'h0, 8'h0, 64'h0, 1'b0, 0);
    txn(32'h000, 64'h0, 8'h0, 64'h0, 1'b0, 0);
    txn(32'h020, 64'hDEADBEEF, 8'hF, 64'h0, 1'b0, 0);
    txn(32'h020, 64'h0, 8'h0, 64'hDEADBEEF, 1'b0, 0);
    txn(32'h020, 64'h11223344, 8'h5, 64'h0, 1'b0, 0);
    txn(32'h020, 64'h0, 8'h0, 64'hDE22BE44, 1'b0, 5);
    txn(32'h022, 64'h0, 8'h0, 64'h0, 1'b1, 0);
    txn(32'h000, 64'hCAFEF00D, 8'hF, 64'h0, 1'b0, 0);
    txn(32'h400, 64'h55555555, 8'hF, 64'h0, 1'b1, 0);
    txn(32'h000, 64'h0, 8'h0, 64'hCAFEF00D, 1'b0, 0);

    // 64-bit, zero wait states, base 0x1000
    sel = 2'd1;
    txn(32'h1008, 64'h0123456789ABCDEF, 8'hF0, 64'h0, 1'b0, 0);
    txn(32'h1008, 64'h0, 8'h0, 64'h01234567_00000000, 1'b0, 2);
    txn(32'h1004, 64'h0, 8'h0, 64'h0, 1'b1, 0);
    txn(32'h0FF8, 64'h0, 8'h0, 64'h0, 1'b1, 0);
    txn(32'h1080, 64'h0, 8'h0, 64'h0, 1'b1, 0);

    // no clear, three wait states: reset during WAIT aborts the write
    sel = 2'd2;
    txn(32'h004, 64'hA5A5A5A5, 8'hF, 64'h0, 1'b0, 0);
    txn(32'h004, 64'h0, 8'h0, 64'hA5A5A5A5, 1'b0, 0);
    @(negedge clk);
    t_addr = 32'h004; t_wdata = 64'h12345678; t_mask = 8'hF; t_valid = 1'b1;
    @(posedge clk); #1; t_valid = 1'b0;
    chk("abort_busy_wait", b2, 1);
    chk("abort_valid_wait", vld2, 0);
    @(negedge clk); rst2 = 1'b0;
    #1;
    chk("abort_valid_rst", vld2, 0);
    chk("abort_busy_rst", b2, 0);
    @(negedge clk); rst2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_no_rsp", vld2, 0);
    end
    txn(32'h004, 64'h0, 8'h0, 64'hA5A5A5A5, 1'b0, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
